// File: rtl/uart_rx_8n1_if.sv
// Byte-side handshake and status of the 8N1 receiver.
// master = receiver, slave = consumer.
interface uart_rx_8n1_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    modport master (
        output rx_data, rx_valid, frame_err, overrun, busy,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_valid, frame_err, overrun, busy,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver: start-bit mid-check, LSB-first data, stop check,
// one-entry valid/ready holding register with framing/overrun pulses.
module uart_rx_8n1 #(
    parameter int CLKS_PER_BIT = 1250
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          rx,
    uart_rx_8n1_if.master bus
);
    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t        state, state_n;
    logic          sync1, rx_s;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic [7:0]    data_q;
    logic          valid_q, ferr_q, ovr_q;

    logic half_done, bit_done;
    logic cnt_clr, shift_en, commit, ferr_set, busy_c;

    assign half_done = (cnt == HALF_LAST);
    assign bit_done  = (cnt == BIT_LAST);

    // Two-flop synchroniser; idles high so reset never looks like a start bit.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= rx;
            rx_s  <= sync1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (!rx_s) state_n = START;
            START:   if (half_done) state_n = rx_s ? IDLE : DATA;
            DATA:    if (bit_done && bit_idx == 3'd7) state_n = STOP;
            STOP:    if (bit_done) state_n = rx_s ? IDLE : BREAK;
            BREAK:   if (rx_s) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        busy_c   = (state != IDLE);
        cnt_clr  = 1'b0;
        shift_en = 1'b0;
        commit   = 1'b0;
        ferr_set = 1'b0;
        case (state)
            IDLE:    cnt_clr = 1'b1;
            START:   cnt_clr = half_done;
            DATA: begin
                cnt_clr  = bit_done;
                shift_en = bit_done;
            end
            STOP: begin
                cnt_clr  = bit_done;
                commit   = bit_done &&  rx_s;
                ferr_set = bit_done && !rx_s;
            end
            BREAK:   cnt_clr = 1'b1;
            default: cnt_clr = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            cnt <= cnt_clr ? '0 : cnt + CW'(1);
            if (state == START) bit_idx <= '0;
            else if (shift_en)  bit_idx <= bit_idx + 3'd1;
            if (shift_en) shreg[bit_idx] <= rx_s;
        end
    end

    // A commit lands if the register is empty or being drained this cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            ferr_q <= ferr_set;
            ovr_q  <= commit && valid_q && !bus.rx_ready;
            if (commit && (!valid_q || bus.rx_ready)) begin
                data_q  <= shreg;
                valid_q <= 1'b1;
            end else if (valid_q && bus.rx_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.rx_data   = data_q;
    assign bus.rx_valid  = valid_q;
    assign bus.frame_err = ferr_q;
    assign bus.overrun   = ovr_q;
    assign bus.busy      = busy_c;
endmodule

// File: tb/tb_uart_rx_8n1.sv
// Directed/randomised bench for uart_rx_8n1 at 16 clocks per bit.
module tb_uart_rx_8n1;
  localparam int CPB = 16;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  logic rx = 1'b1;
  uart_rx_8n1_if bus();

  uart_rx_8n1 #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .resetn(resetn), .rx(rx), .bus(bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0, miscompares = 0;
  int start_cyc = 0;

  // Observer: everything the consumer would see, sampled mid-cycle.
  logic [7:0] got_q[$];
  int ferr_cnt = 0, ovr_cnt = 0, busy_cnt = 0, rise_cyc = -1;
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    if (bus.rx_valid && bus.rx_ready) got_q.push_back(bus.rx_data);
    if (bus.frame_err) ferr_cnt++;
    if (bus.overrun) ovr_cnt++;
    if (bus.busy) busy_cnt++;
    if (bus.rx_valid && !prev_valid) rise_cyc = cyc;
    prev_valid = bus.rx_valid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    tick(CPB);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    start_cyc = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
  endtask

  task automatic expect_pop(input string tag, input logic [7:0] exp);
    logic [31:0] v;
    v = 'x;
    if (got_q.size() != 0) v = {24'd0, got_q.pop_front()};
    check(tag, v, {24'd0, exp});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] stream[$];
    logic [7:0] ovr_bytes[$];
    int f0, o0, b0, lat, n;

    bus.rx_ready = 1'b0;
    #1 resetn = 1'b0;
    #1;
    check("reset_valid", bus.rx_valid, 0);
    check("reset_data", bus.rx_data, 0);
    check("reset_ferr", bus.frame_err, 0);
    check("reset_ovr", bus.overrun, 0);
    check("reset_busy", bus.busy, 0);
    tick(3);
    resetn = 1'b1;
    tick(CPB);

    // Single byte with consumer stalled, then a one-cycle accept.
    send_frame(8'h68, 1'b1);
    lat = rise_cyc - start_cyc;
    check("single_latency_155pm1", (lat >= 154 && lat <= 156), 1);
    check("single_valid", bus.rx_valid, 1);
    check("single_data", bus.rx_data, 8'h68);
    bus.rx_ready = 1'b1;
    tick(1);
    bus.rx_ready = 1'b0;
    check("single_valid_drop", bus.rx_valid, 0);
    expect_pop("single_accepted", 8'h68);

    // Short low pulse must be rejected at the start mid-check.
    f0 = ferr_cnt; o0 = ovr_cnt; b0 = busy_cnt;
    rx = 1'b0; tick(3); rx = 1'b1; tick(3 * CPB);
    check("glitch_busy_seen", busy_cnt > b0, 1);
    check("glitch_busy_idle", bus.busy, 0);
    check("glitch_no_valid", bus.rx_valid, 0);
    check("glitch_no_ferr", ferr_cnt - f0, 0);
    check("glitch_no_ovr", ovr_cnt - o0, 0);

    // Bad stop bit followed by a 40-bit break, then a clean frame.
    bus.rx_ready = 1'b1;
    f0 = ferr_cnt;
    send_frame(8'h55, 1'b0);
    rx = 1'b0; tick(40 * CPB);
    check("break_one_ferr", ferr_cnt - f0, 1);
    check("break_no_bytes", got_q.size(), 0);
    check("break_busy", bus.busy, 1);
    rx = 1'b1; tick(2 * CPB);
    send_frame(8'hA3, 1'b1);
    tick(CPB);
    expect_pop("after_break", 8'hA3);
    check("after_break_ferr", ferr_cnt - f0, 1);

    // Back-to-back stream, always ready: every frame delivered in order.
    stream = '{8'h68, 8'h61, 8'h72, 8'h73, 8'h68, 8'h69, 8'h74, 8'h68, 8'h42};
    for (int i = 0; i < 8; i++) stream.push_back(8'($urandom));
    f0 = ferr_cnt; o0 = ovr_cnt;
    foreach (stream[i]) send_frame(stream[i], 1'b1);
    tick(CPB);
    check("stream_count", got_q.size(), stream.size());
    foreach (stream[i]) expect_pop($sformatf("stream_byte%0d", i), stream[i]);
    check("stream_no_ferr", ferr_cnt - f0, 0);
    check("stream_no_ovr", ovr_cnt - o0, 0);

    // Overrun: stalled consumer keeps the first byte, each later one drops.
    bus.rx_ready = 1'b0;
    for (int pass = 0; pass < 2; pass++) begin
      ovr_bytes.delete();
      if (pass == 0) ovr_bytes = '{8'h11, 8'h22};
      else begin
        n = $urandom_range(2, 4);
        for (int i = 0; i < n; i++) ovr_bytes.push_back(8'($urandom));
      end
      o0 = ovr_cnt;
      foreach (ovr_bytes[i]) send_frame(ovr_bytes[i], 1'b1);
      tick(CPB);
      check($sformatf("ovr%0d_pulses", pass), ovr_cnt - o0, ovr_bytes.size() - 1);
      check($sformatf("ovr%0d_held", pass), bus.rx_data, ovr_bytes[0]);
      check($sformatf("ovr%0d_valid", pass), bus.rx_valid, 1);
      bus.rx_ready = 1'b1;
      tick(1);
      bus.rx_ready = 1'b0;
      check($sformatf("ovr%0d_drained", pass), bus.rx_valid, 0);
      expect_pop($sformatf("ovr%0d_accepted", pass), ovr_bytes[0]);
      check($sformatf("ovr%0d_nothing_more", pass), got_q.size(), 0);
    end

    // Asynchronous reset in the middle of data bit 4 of 0xF0.
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    rx = 1'b1;
    tick(CPB / 2);
    check("midframe_busy", bus.busy, 1);
    resetn = 1'b0;
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_valid", bus.rx_valid, 0);
    check("rst_data", bus.rx_data, 0);
    check("rst_ferr", bus.frame_err, 0);
    check("rst_ovr", bus.overrun, 0);
    tick(3);
    resetn = 1'b1;
    tick(CPB);
    bus.rx_ready = 1'b1;
    send_frame(8'h3C, 1'b1);
    tick(CPB);
    expect_pop("after_reset", 8'h3C);
    check("after_reset_empty", got_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/uart_rx_8n1.md
# uart_rx_8n1

Receive-side UART for the board's serial link: recovers 8N1 frames (1 start, 8 data LSB-first, 1 stop, no parity) from the `uartrx` pin. It runs on the system clock with a parameterised bit period and presents each received byte through a one-entry valid/ready holding register. It sits between the `uartrx` pad and any consumer, such as a command parser or a loopback to `uart_tx_8n1`. It flags framing errors and overruns as single-cycle pulses.

## Interface
- `CLKS_PER_BIT`, default 1250: system clocks per bit (12 MHz / 9600). Legal values are ≥ 4. `HALF` = `CLKS_PER_BIT/2`, truncated.
- `clk`  in  1: system clock. All logic is on the rising edge.
- `resetn`  in  1: asynchronous, active-low reset.
- `rx`  in  1: serial line, asynchronous to `clk`. Idles high.
- `rx_data`  out  8: received byte. Valid while `rx_valid` = 1.
- `rx_valid`  out  1: holding register full.
- `rx_ready`  in  1: consumer accepts the byte on a cycle where `rx_valid && rx_ready`.
- `frame_err`  out  1: one-cycle pulse when the stop bit is sampled low.
- `overrun`  out  1: one-cycle pulse when a new byte is dropped.
- `busy`  out  1: high whenever the FSM is not in IDLE.

## Operation
- **Input synchroniser:** `rx` passes through a 2-flop synchroniser (both flops reset to 1). All decisions use the synchronised value `rx_s`.
- **Bit counter:** `$clog2(CLKS_PER_BIT)` bits wide. Bit index is 3 bits.
- **FSM states:** IDLE, START, DATA, STOP, BREAK.
- **IDLE:**
  - On `rx_s` = 0, go to START and clear the counter.
- **START:**
  - Count to `HALF`-1. At that point, sample `rx_s`.
  - If `rx_s` = 0, go to DATA with bit index 0 and clear the counter.
  - If `rx_s` = 1, treat it as a glitch and return to IDLE. No flags are raised.
- **DATA:**
  - Count to `CLKS_PER_BIT`-1, then sample `rx_s` into shift-register bit [index] (LSB first).
  - After bit 7 is sampled, go to STOP.
- **STOP:**
  - Count to `CLKS_PER_BIT`-1, then sample `rx_s`.
  - If `rx_s` = 1, commit the byte and go to IDLE. This re-arms half a bit early so back-to-back frames resynchronise on the next start edge.
  - If `rx_s` = 0, pulse `frame_err`, discard the byte, and go to BREAK.
- **BREAK:**
  - Wait until `rx_s` = 1, then go to IDLE. This prevents a held-low line from being decoded as 0x00 frames.
- **Commit** (same clock as the stop sample is registered):
  - If `rx_valid` = 0: load `rx_data` and set `rx_valid` = 1.
  - If `rx_valid` = 1 and `rx_ready` = 1 on that cycle: the old byte is consumed, the new byte loads, and `rx_valid` stays 1.
  - If `rx_valid` = 1 and `rx_ready` = 0: pulse `overrun`. The new byte is dropped and `rx_data` keeps the old byte.
- **Handshake:**
  - `rx_valid` falls on the cycle after `rx_valid && rx_ready`, unless a commit happens on that same cycle.
  - `rx_data` is stable while `rx_valid` = 1 and no accept has occurred.
- **Reset:** takes effect at any time, including mid-frame. It aborts the frame and forces:
  - FSM = IDLE
  - `rx_data` = 0x00
  - `rx_valid`, `frame_err`, `overrun`, `busy` = 0
  - synchroniser flops = 1
- After reset deasserts, a line that is already low is treated as a start edge. Benches drive `rx` = 1 during reset.

## Timing
- Pin to `rx_s`: 2 clocks.
- Start-mid check: `HALF` clocks after IDLE first sees `rx_s` = 0.
- Data samples: at `HALF` + k·`CLKS_PER_BIT` clocks, for k = 1..8.
- Stop sample: at `HALF` + 9·`CLKS_PER_BIT`.
- `rx_valid` / `frame_err` / `overrun`: registered, asserted 1 clock after the stop sample.
- Pin falling edge to `rx_valid` = 1: 2 + `HALF` + 9·`CLKS_PER_BIT` + 1 clocks, ±1 for synchroniser phase.
- Baud tolerance: at least ±4% for `CLKS_PER_BIT` ≥ 16.
- `busy` is high from the clock after start detection through the stop sample or BREAK exit.

## Test plan
All tests use `CLKS_PER_BIT` = 16.
- **Single byte:** send 0x68 with `rx_ready` = 0 → `rx_valid` = 1 with `rx_data` = 0x68 exactly 2+8+144+1 clocks after the edge (±1). Raising `rx_ready` for 1 cycle → `rx_valid` = 0 next cycle.
- **Glitch rejection:** drive `rx` low for 3 clocks, then high → `busy` pulses, then returns to 0. No `rx_valid`, `frame_err`, or `overrun`.
- **Framing error / break:** send 0x55 with the stop bit low, then hold `rx` low for 40 bits → exactly one `frame_err` pulse and no `rx_valid`. After the line returns high, 0xA3 is received correctly.
- **Back-to-back stream:** send "harshithB" (0x68 61 72 73 68 69 74 68 42) with zero idle bits and `rx_ready` tied to 1 → nine bytes in order, no flags.
- **Overrun:** send 0x11 then 0x22 with `rx_ready` = 0 → one `overrun` pulse at the second commit. `rx_data` stays 0x11. After accept, `rx_valid` = 0.
- **Reset mid-frame:** assert `resetn` = 0 during data bit 4 of 0xF0 → all outputs are 0 immediately (asynchronously). After release with `rx` high, 0x3C is received correctly.
